// File: rtl/display_timings_1080p.sv
// Video timing generator, 1920x1080 (CEA-861 1080p) by default.
// Waits for the pixel clock to hold lock for LOCK_CYCLES consecutive cycles,
// then scans raster coordinates with syncs, data enable and line/frame strobes.
// Ports:
//   clk_pix        pixel clock
//   rst_pix_n      synchronous active-low reset
//   clk_pix_locked pixel clock lock, already in the clk_pix domain
//   sx, sy         current pixel position
//   de             active-video data enable
//   hsync, vsync   active-high syncs
//   line, frame    one-cycle strobes at sx=0 / at sx=0,sy=0
//   running        timing is being generated
//   frame_cnt      frames started since entering RUN (first frame is 0)
module display_timings_1080p #(
  parameter int unsigned H_RES       = 1920,
  parameter int unsigned H_FP        = 88,
  parameter int unsigned H_SYNC      = 44,
  parameter int unsigned H_BP        = 148,
  parameter int unsigned V_RES       = 1080,
  parameter int unsigned V_FP        = 4,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_BP        = 36,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned CORDW       = 12
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             clk_pix_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame,
  output logic             running,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned LCW   = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOT - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOT - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG   = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG   = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [LCW-1:0]   LOCK_END = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [LCW-1:0]   lock_cnt, lock_cnt_n;
  logic [CORDW-1:0] sx_n, sy_n;
  logic [15:0]      frame_cnt_n;
  logic             run_n, de_n, hsync_n, vsync_n, line_n, frame_n;

  // Next state and the coordinates of the pixel presented next cycle;
  // every output is then decoded from these so all registers stay aligned.
  always_comb begin
    state_n     = state;
    lock_cnt_n  = '0;
    sx_n        = '0;
    sy_n        = '0;
    frame_cnt_n = '0;
    run_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clk_pix_locked) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!clk_pix_locked) begin
          state_n = ST_IDLE;
        end else if (lock_cnt == LOCK_END) begin
          // first RUN cycle shows pixel (0,0) and frame_cnt 0
          state_n = ST_RUN;
          run_n   = 1'b1;
        end else begin
          lock_cnt_n = lock_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!clk_pix_locked) begin
          state_n = ST_IDLE;
        end else begin
          run_n       = 1'b1;
          frame_cnt_n = frame_cnt;
          if (sx == H_LAST) begin
            if (sy == V_LAST) begin
              frame_cnt_n = frame_cnt + 16'd1;
            end else begin
              sy_n = sy + 1'b1;
            end
          end else begin
            sx_n = sx + 1'b1;
            sy_n = sy;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    de_n    = run_n && (sx_n < H_ACT) && (sy_n < V_ACT);
    hsync_n = run_n && (sx_n >= HS_BEG) && (sx_n < HS_END);
    vsync_n = run_n && (sy_n >= VS_BEG) && (sy_n < VS_END);
    line_n  = run_n && (sx_n == '0);
    frame_n = line_n && (sy_n == '0);
  end

  // State and output registers
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state     <= ST_IDLE;
      lock_cnt  <= '0;
      sx        <= '0;
      sy        <= '0;
      de        <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      line      <= 1'b0;
      frame     <= 1'b0;
      running   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_cnt_n;
      sx        <= sx_n;
      sy        <= sy_n;
      de        <= de_n;
      hsync     <= hsync_n;
      vsync     <= vsync_n;
      line      <= line_n;
      frame     <= frame_n;
      running   <= run_n;
      frame_cnt <= frame_cnt_n;
    end
  end

endmodule

// File: tb/tb_display_timings_1080p.sv
// Directed bench: default 1080p instance for lock/start/line timing and
// a tiny-raster instance for frame wrap, vsync and frame_cnt rollover.
module tb_display_timings_1080p;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic        clk_pix_locked;

  logic [11:0] sx, sy, s_sx, s_sy;
  logic        de, hsync, vsync, line, frame, running;
  logic        s_de, s_hsync, s_vsync, s_line, s_frame, s_running;
  logic [15:0] frame_cnt, s_frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_pix = ~clk_pix;

  display_timings_1080p u_dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .clk_pix_locked(clk_pix_locked),
    .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync), .line(line),
    .frame(frame), .running(running), .frame_cnt(frame_cnt)
  );

  display_timings_1080p #(
    .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .clk_pix_locked(clk_pix_locked),
    .sx(s_sx), .sy(s_sy), .de(s_de), .hsync(s_hsync), .vsync(s_vsync),
    .line(s_line), .frame(s_frame), .running(s_running), .frame_cnt(s_frame_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_pix);
      #1;
    end
  endtask

  // Holds lock high and confirms RUN appears on exactly the 17th edge.
  task automatic expect_start(input string tag);
    for (int i = 1; i <= 17; i++) begin
      tick(1);
      if (i == 16) check({tag, "_not_yet"}, int'(running), 0);
    end
    check({tag, "_running"}, int'(running), 1);
    check({tag, "_frame"}, int'(frame), 1);
    check({tag, "_line"}, int'(line), 1);
    check({tag, "_sx"}, int'(sx), 0);
    check({tag, "_sy"}, int'(sy), 0);
    check({tag, "_fcnt"}, int'(frame_cnt), 0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_sx"}, int'(sx), 0);
    check({tag, "_sy"}, int'(sy), 0);
    check({tag, "_flags"}, int'({de, hsync, vsync, line, frame}), 0);
    check({tag, "_fcnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, ln_cnt, ramp_err;
    int vs_cnt, fr_cnt, sx_max, sy_max;

    // Reset
    rst_pix_n      = 1'b0;
    clk_pix_locked = 1'b0;
    tick(3);
    expect_reset_outputs("reset");
    rst_pix_n = 1'b1;
    tick(2);
    check("idle_unlocked", int'(running), 0);

    // Clean lock -> start after 1 IDLE + 16 WAIT
    clk_pix_locked = 1'b1;
    expect_start("start");
    check("start_de", int'(de), 1);

    // One full line at default timing
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ln_cnt = 0; ramp_err = 0;
    for (int c = 0; c < 2200; c++) begin
      if (int'(sx) != c || sy != 12'd0) ramp_err++;
      if (de) de_cnt++;
      if (line) ln_cnt++;
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      tick(1);
    end
    check("line_ramp_err", ramp_err, 0);
    check("line_de_cnt", de_cnt, 1920);
    check("line_hs_first", hs_first, 2008);
    check("line_hs_last", hs_last, 2051);
    check("line_hs_cnt", hs_cnt, 44);
    check("line_pulses", ln_cnt, 1);
    check("wrap_sx", int'(sx), 0);
    check("wrap_sy", int'(sy), 1);
    check("wrap_line", int'(line), 1);
    check("wrap_frame", int'(frame), 0);

    // Lock drop mid-line
    tick(1000);
    check("pre_drop_sx", int'(sx), 1000);
    clk_pix_locked = 1'b0;
    tick(1);
    expect_reset_outputs("drop");

    // Lock glitch in WAIT restarts the count
    clk_pix_locked = 1'b1;
    tick(10);
    check("glitch_wait", int'(running), 0);
    clk_pix_locked = 1'b0;
    tick(1);
    check("glitch_low", int'(running), 0);
    clk_pix_locked = 1'b1;
    expect_start("relock");

    // Reset mid-frame with lock held
    tick(500);
    check("pre_rst_sx", int'(sx), 500);
    rst_pix_n = 1'b0;
    tick(1);
    expect_reset_outputs("midrst");
    rst_pix_n = 1'b1;
    expect_start("rst_restart");

    // Tiny raster: 7x5, one frame = 35 cycles
    check("small_start", int'(s_frame), 1);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ln_cnt = 0; fr_cnt = 0; sx_max = 0; sy_max = 0;
    for (int c = 0; c < 35; c++) begin
      if (s_de) de_cnt++;
      if (s_hsync) begin
        hs_cnt++;
        if (s_sx != 12'd5) ramp_err++;
      end
      if (s_vsync) begin
        vs_cnt++;
        if (s_sy != 12'd3) ramp_err++;
      end
      if (s_line) ln_cnt++;
      if (s_frame) fr_cnt++;
      if (int'(s_sx) > sx_max) sx_max = int'(s_sx);
      if (int'(s_sy) > sy_max) sy_max = int'(s_sy);
      tick(1);
    end
    check("small_de", de_cnt, 8);
    check("small_hs", hs_cnt, 5);
    check("small_vs", vs_cnt, 7);
    check("small_sync_pos_err", ramp_err, 0);
    check("small_lines", ln_cnt, 5);
    check("small_frames", fr_cnt, 1);
    check("small_sx_max", sx_max, 6);
    check("small_sy_max", sy_max, 4);
    check("small_frame2", int'(s_frame), 1);
    check("small_fcnt1", int'(s_frame_cnt), 1);
    tick(35);
    check("small_fcnt2", int'(s_frame_cnt), 2);

    // frame_cnt rollover
    force u_small.frame_cnt = 16'hFFFF;
    tick(3);
    release u_small.frame_cnt;
    tick(1);
    check("small_fcnt_max", int'(s_frame_cnt), 65535);
    tick(31);
    check("small_wrap_frame", int'(s_frame), 1);
    check("small_fcnt_wrap", int'(s_frame_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
